// File: rtl/pipelined_shifter_if.sv
// Handshake bundle between the shifter and its upstream/downstream.
// master: in_* and out_ready; slave: in_ready and out_*. The optional
// out_zero/out_msb flag ports exist only with PIPELINED_SHIFTER_FLAGS_EN.
interface pipelined_shifter_if #(
   parameter int WIDTH = 16
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
   logic             out_zero;
   logic             out_msb;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_msb
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_msb
   );
`else
   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
`endif
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRA/ROR/SRL shifter, one shamt bit (MSB first) per stage.
// Ports: clk, rst_n (sync, active-low), bus (pipelined_shifter_if.slave):
//   in_valid/in_ready/in_data/in_shamt/in_mode, out_valid/out_ready/out_data.
// Macro PIPELINED_SHIFTER_FLAGS_EN adds registered out_zero and out_msb.
module pipelined_shifter #(
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_shifter_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRA = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;
   localparam logic [1:0] MODE_SRL = 2'b11;

   // Stage state. The last stage has no shift left to do, so it keeps
   // only valid and data; mode/shamt live in stages 1..SHW-1.
   logic [SHW:1]     v_q, v_d;
   logic [WIDTH-1:0] data_q [1:SHW];
   logic [WIDTH-1:0] data_d [1:SHW];
   logic [1:0]       mode_q [1:SHW-1];
   logic [1:0]       mode_d [1:SHW-1];
   logic [SHW-1:0]   shamt_q [1:SHW-1];
   logic [SHW-1:0]   shamt_d [1:SHW-1];

   logic [SHW:1]     adv;

   // Stage k's upstream is src[k-1]; src[0] is the input port.
   logic [SHW-1:0]   src_v;
   logic [WIDTH-1:0] src_data [0:SHW-1];
   logic [1:0]       src_mode [0:SHW-1];
   logic [SHW-1:0]   src_shamt [0:SHW-1];

   function automatic logic [WIDTH-1:0] step(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       m,
      input int               amt
   );
      logic [WIDTH-1:0] r;
      r = d;
      unique case (m)
         MODE_SLL: r = d << amt;
         MODE_SRA: r = WIDTH'($signed(d) >>> amt);
         MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
         MODE_SRL: r = d >> amt;
      endcase
      return r;
   endfunction

   // A stage advances if the output drains or any stage from it to
   // the end is empty; built from a running "all full" term so the
   // chain has no self-referencing bits.
   always_comb begin
      logic full;
      full = 1'b1;
      adv  = '0;
      for (int k = SHW; k >= 1; k--) begin
         full   = full & v_q[k];
         adv[k] = bus.out_ready | ~full;
      end
   end

   always_comb begin
      src_v[0]     = bus.in_valid & adv[1];
      src_data[0]  = bus.in_data;
      src_mode[0]  = bus.in_mode;
      src_shamt[0] = bus.in_shamt;
      for (int k = 1; k < SHW; k++) begin
         src_v[k]     = v_q[k];
         src_data[k]  = data_q[k];
         src_mode[k]  = mode_q[k];
         src_shamt[k] = shamt_q[k];
      end

      v_d = v_q;
      for (int k = 1; k <= SHW; k++) begin
         data_d[k] = data_q[k];
         if (adv[k]) begin
            v_d[k] = src_v[k-1];
            if (src_shamt[k-1][SHW-k])
               data_d[k] = step(src_data[k-1], src_mode[k-1],
                                1 << (SHW - k));
            else
               data_d[k] = src_data[k-1];
         end
      end

      for (int k = 1; k < SHW; k++) begin
         mode_d[k]  = mode_q[k];
         shamt_d[k] = shamt_q[k];
         if (adv[k]) begin
            mode_d[k]  = src_mode[k-1];
            shamt_d[k] = src_shamt[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 1; k <= SHW; k++) data_q[k] <= '0;
         for (int k = 1; k < SHW; k++) begin
            mode_q[k]  <= '0;
            shamt_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 1; k <= SHW; k++) data_q[k] <= data_d[k];
         for (int k = 1; k < SHW; k++) begin
            mode_q[k]  <= mode_d[k];
            shamt_q[k] <= shamt_d[k];
         end
      end
   end

   assign bus.in_ready  = adv[1];
   assign bus.out_valid = v_q[SHW];
   assign bus.out_data  = data_q[SHW];

`ifdef PIPELINED_SHIFTER_FLAGS_EN
   // Flags follow the last stage's data, so they hold on stall too.
   logic zero_q, zero_d;
   logic msb_q, msb_d;

   always_comb begin
      zero_d = (data_d[SHW] == '0);
      msb_d  = data_d[SHW][WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         msb_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         msb_q  <= msb_d;
      end
   end

   assign bus.out_zero = zero_q;
   assign bus.out_msb  = msb_q;
`endif
endmodule
